vote_collector: RTL and testbench



---
 rtl/vote_collector.sv | 117 +++++++++++
 tb/tb_vote_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vote_collector.sv
// Voting front end: synchronises and debounces three voter keys, then latches
// each voter's first press during a fixed window started by start.
module vote_collector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 16,
  localparam int RW             = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    key,
  output logic [2:0]    votes,
  output logic          votes_valid,
  output logic          voting,
  output logic [RW-1:0] remaining
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] WIN_LOAD = RW'(WINDOW_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTING = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [2:0]    sync1;
  logic [2:0]    ks;
  logic [2:0]    db;
  logic [2:0]    db_d;
  logic [CW-1:0] cnt [3];
  logic [2:0]    press;
  logic [2:0]    votes_nx;
  logic [RW-1:0] remaining_nx;

  // Two-flop synchroniser and per-channel debounce; db only toggles after
  // ks has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'b000;
      ks    <= 3'b000;
      db    <= 3'b000;
      db_d  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= {CW{1'b0}};
      end
    end else begin
      sync1 <= key;
      ks    <= sync1;
      db_d  <= db;
      for (int i = 0; i < 3; i++) begin
        if (ks[i] == db[i]) begin
          cnt[i] <= {CW{1'b0}};
        end else if (cnt[i] == DB_LAST) begin
          cnt[i] <= {CW{1'b0}};
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = db & ~db_d;

  // State, vote and window-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      votes     <= 3'b000;
      remaining <= {RW{1'b0}};
    end else begin
      state     <= state_nx;
      votes     <= votes_nx;
      remaining <= remaining_nx;
    end
  end

  // Next-state logic; a press on the closing edge is still merged into votes.
  always_comb begin
    state_nx     = state;
    votes_nx     = votes;
    remaining_nx = remaining;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx     = VOTING;
          votes_nx     = 3'b000;
          remaining_nx = WIN_LOAD;
        end else begin
          state_nx = state;
        end
      end
      VOTING: begin
        votes_nx = votes | press;
        if ((remaining == RW'(1)) || ((votes | press) == 3'b111)) begin
          state_nx     = DONE;
          remaining_nx = {RW{1'b0}};
        end else begin
          remaining_nx = remaining - RW'(1);
        end
      end
      default: begin
        state_nx     = IDLE;
        votes_nx     = 3'b000;
        remaining_nx = {RW{1'b0}};
      end
    endcase
  end

  assign voting      = (state == VOTING);
  assign votes_valid = (state == DONE);

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: expected vote vectors are queued when a
// window's stimulus is driven and compared when votes_valid is observed.
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] key;
  logic [2:0] votes;
  logic       votes_valid;
  logic       voting;
  logic [4:0] remaining;

  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q [$];
  logic       both_seen = 1'b0;
  logic       seen;

  vote_collector dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key         (key),
    .votes       (votes),
    .votes_valid (votes_valid),
    .voting      (voting),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (voting === 1'b1 && votes_valid === 1'b1) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    logic [2:0] e = 3'bxxx;
    while (votes_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(votes_valid), 32'd1);
    check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_votes"}, 32'(votes), 32'(e));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    key   = 3'($urandom);

    // reset values
    tick();
    key = 3'($urandom);
    tick();
    check("rst_votes", 32'(votes), 32'd0);
    check("rst_rem", 32'(remaining), 32'd0);
    check("rst_voting", 32'(voting), 32'd0);
    check("rst_valid", 32'(votes_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key = 3'($urandom);
      tick();
    end
    check("idle_votes", 32'(votes), 32'd0);
    check("idle_voting", 32'(voting), 32'd0);
    key = 3'b000;
    repeat (10) tick();

    // partial vote over a full window
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_voting0", 32'(voting), 32'd1);
    check("t2_rem0", 32'(remaining), 32'd16);
    check("t2_valid0", 32'(votes_valid), 32'd0);
    key = 3'b011;
    exp_q.push_back(3'b011);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 10) key = 3'b000;
      check("t2_rem", 32'(remaining), 32'(16 - i));
      check("t2_voting", 32'(voting), 32'd1);
    end
    tick();
    check("t2_voting_end", 32'(voting), 32'd0);
    check("t2_rem_end", 32'(remaining), 32'd0);
    wait_done("t2", 0);
    repeat (3) tick();
    check("t2_frozen_valid", 32'(votes_valid), 32'd1);
    check("t2_frozen_votes", 32'(votes), 32'd3);

    // early close from DONE, staggered presses
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_valid_drop", 32'(votes_valid), 32'd0);
    check("t3_voting", 32'(voting), 32'd1);
    check("t3_votes_clr", 32'(votes), 32'd0);
    key = 3'b001;
    repeat (2) tick();
    key = 3'b011;
    repeat (2) tick();
    key = 3'b111;
    exp_q.push_back(3'b111);
    repeat (6) tick();
    check("t3_rem_e10", 32'(remaining), 32'd6);
    check("t3_valid_e10", 32'(votes_valid), 32'd0);
    tick();
    check("t3_valid_e11", 32'(votes_valid), 32'd1);
    check("t3_rem_e11", 32'(remaining), 32'd0);
    wait_done("t3", 0);
    key = 3'b000;
    repeat (10) tick();

    // glitch rejection then a qualifying pulse on voter 2
    start = 1'b1;
    tick();
    start = 1'b0;
    key = 3'b100;
    repeat (3) tick();
    key = 3'b000;
    repeat (5) tick();
    check("t4_glitch", 32'(votes), 32'd0);
    key = 3'b100;
    exp_q.push_back(3'b100);
    repeat (6) tick();
    check("t4_before", 32'(votes), 32'd0);
    key = 3'b000;
    tick();
    check("t4_after", 32'(votes), 32'd4);
    wait_done("t4", 10);
    repeat (10) tick();

    // key held across window open does not count
    key = 3'b001;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(3'b000);
    wait_done("t5a", 20);
    key = 3'b000;
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    key = 3'b001;
    exp_q.push_back(3'b001);
    wait_done("t5b", 20);
    key = 3'b000;
    repeat (10) tick();

    // reset mid-window
    start = 1'b1;
    tick();
    start = 1'b0;
    key = 3'b001;
    repeat (8) tick();
    check("t6_rem8", 32'(remaining), 32'd8);
    check("t6_votes", 32'(votes), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    key = 3'b000;
    check("t6_voting", 32'(voting), 32'd0);
    check("t6_votes_clr", 32'(votes), 32'd0);
    check("t6_rem", 32'(remaining), 32'd0);
    check("t6_valid", 32'(votes_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen = seen | votes_valid | voting;
    end
    check("t6_no_result", 32'(seen), 32'd0);

    check("never_both", 32'(both_seen), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
